// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared types and sizes for the register-file write arbiter.
//   XLEN       : register data width
//   AW         : register address width
//   NUM_REGS   : number of architectural registers (width of the busy mask)
//   wq_entry_t : one queued mul/div write {destination, data}
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wq_entry_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter_if
// Bundles every signal between the pipeline / mul-div unit and the
// register-file write arbiter.
//   master : pipeline side (drives WB and MD requests, sees grant/status)
//   slave  : arbiter side
// Signals:
//   RegWriteW/RdW/ResultW   WB write request
//   MdIssue/MdIssueRd       MD op issued by decode
//   MdValid/MdRd/MdResult   MD result offer, accepted when MdReady
//   RfWE/RfWA/RfWD          register-file write port
//   BusyMask                pending MD destinations
//   StallReq                request for a WB bubble
// ---------------------------------------------------------------------------
interface rf_write_arbiter_if;
    import rf_pkg::*;

    logic                RegWriteW;
    logic [AW-1:0]       RdW;
    logic [XLEN-1:0]     ResultW;
    logic                MdIssue;
    logic [AW-1:0]       MdIssueRd;
    logic                MdValid;
    logic [AW-1:0]       MdRd;
    logic [XLEN-1:0]     MdResult;
    logic                MdReady;
    logic                RfWE;
    logic [AW-1:0]       RfWA;
    logic [XLEN-1:0]     RfWD;
    logic [NUM_REGS-1:0] BusyMask;
    logic                StallReq;

    modport master (
        output RegWriteW, RdW, ResultW, MdIssue, MdIssueRd, MdValid, MdRd, MdResult,
        input  MdReady, RfWE, RfWA, RfWD, BusyMask, StallReq
    );

    modport slave (
        input  RegWriteW, RdW, ResultW, MdIssue, MdIssueRd, MdValid, MdRd, MdResult,
        output MdReady, RfWE, RfWA, RfWD, BusyMask, StallReq
    );

endinterface

// File: rtl/rf_wq_fifo.sv
// ---------------------------------------------------------------------------
// rf_wq_fifo
// DEPTH-entry synchronous FIFO holding queued mul/div register writes.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (empties the queue)
//   push, wr_entry  enqueue request and entry (ignored when full)
//   pop             dequeue request (ignored when empty)
//   head            oldest entry, valid while !empty
//   full, empty     status flags from the registered count
//   count           number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module rf_wq_fifo
    import rf_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  wq_entry_t     wr_entry,
    output wq_entry_t     head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wq_entry_t     mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; the registered count qualifies it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
// Shares the register file's single write port between the WB stage
// (absolute priority, never stalls) and the multi-cycle mul/div unit,
// whose results wait in a small queue and drain into idle WB slots.
// Also keeps the busy-register scoreboard for decode and raises StallReq
// when the queue head has waited STARVE_LIMIT cycles.
// Ports:
//   clk   clock
//   rst   asynchronous active-low reset
//   bus   rf_write_arbiter_if.slave (WB request, MD issue/result,
//         RF write port, BusyMask, StallReq, MdReady)
// ---------------------------------------------------------------------------
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    rf_write_arbiter_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wq_entry_t           head;
    wq_entry_t           wr_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic                wb_grant;
    logic                md_push;
    logic                md_pop;
    logic [SW-1:0]       starve_cnt;
    logic [SW-1:0]       starve_nxt;
    logic                stall_req;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;

    // A WB write to x0 is not a real write and leaves the slot idle.
    assign wb_grant = bus.RegWriteW && (bus.RdW != '0);

    // Ready comes from the registered count only, so a full queue refuses
    // a result even in a cycle where it also pops.
    assign bus.MdReady = (fifo_count < CW'(DEPTH));

    // Results for x0 complete the handshake but are never queued.
    assign md_push  = bus.MdValid && !fifo_full && (bus.MdRd != '0);
    assign md_pop   = rst && !wb_grant && !fifo_empty;
    assign wr_entry = '{rd: bus.MdRd, data: bus.MdResult};

    rf_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (md_push),
        .pop      (md_pop),
        .wr_entry (wr_entry),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Write-port grant: WB first, then the queue head, else idle.
    always_comb begin
        bus.RfWE = 1'b0;
        bus.RfWA = '0;
        bus.RfWD = '0;
        if (rst) begin
            if (wb_grant) begin
                bus.RfWE = 1'b1;
                bus.RfWA = bus.RdW;
                bus.RfWD = bus.ResultW;
            end else if (!fifo_empty) begin
                bus.RfWE = 1'b1;
                bus.RfWA = head.rd;
                bus.RfWD = head.data;
            end
        end
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (fifo_empty || md_pop) begin
            starve_nxt = '0;
        end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
            starve_nxt = starve_cnt + 1'b1;
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    always_comb begin
        busy_nxt = busy;
        if (md_pop) busy_nxt[head.rd] = 1'b0;
        if (bus.MdIssue && (bus.MdIssueRd != '0)) busy_nxt[bus.MdIssueRd] = 1'b1;
    end

    // StallReq tracks the new counter value so it drops right after the pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
            busy       <= '0;
        end else begin
            starve_cnt <= starve_nxt;
            stall_req  <= (starve_nxt == SW'(STARVE_LIMIT));
            busy       <= busy_nxt;
        end
    end

    assign bus.BusyMask = busy;
    assign bus.StallReq = stall_req;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
// Directed bench for rf_write_arbiter (DEPTH=2, STARVE_LIMIT=4): a table of
// one-cycle vectors with hand-computed outputs, plus hand-written sequences
// for reset, starvation, same-cycle scoreboard and push/pop ordering.
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        iss;
        logic [4:0]  ird;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_rdy;
        logic        e_stall;
        logic [31:0] e_busy;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    vec_t tbl [13];

    rf_write_arbiter_if ifc ();

    rf_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic we, input logic [4:0] rd, input logic [31:0] res,
        input logic iss, input logic [4:0] ird,
        input logic mv, input logic [4:0] mrd, input logic [31:0] mres,
        input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
        input logic e_rdy, input logic e_stall, input logic [31:0] e_busy);
        vec_t v;
        v.we = we;     v.rd = rd;     v.res = res;
        v.iss = iss;   v.ird = ird;
        v.mv = mv;     v.mrd = mrd;   v.mres = mres;
        v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
        v.e_rdy = e_rdy; v.e_stall = e_stall; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] res,
                         input logic iss, input logic [4:0] ird,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mres);
        ifc.RegWriteW = we;
        ifc.RdW       = rd;
        ifc.ResultW   = res;
        ifc.MdIssue   = iss;
        ifc.MdIssueRd = ird;
        ifc.MdValid   = mv;
        ifc.MdRd      = mrd;
        ifc.MdResult  = mres;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Decode guarantees: no reissue to a busy register (unless that register
    // is popped this very cycle) and no WB write to a busy register.
    task automatic legality();
        logic pop_now;
        pop_now = ifc.RfWE && !(ifc.RegWriteW && (ifc.RdW != 5'd0));
        if (rst && ifc.MdIssue && (ifc.MdIssueRd != 5'd0)) begin
            checks++;
            a_reissue: assert (!ifc.BusyMask[ifc.MdIssueRd] ||
                               (pop_now && (ifc.RfWA == ifc.MdIssueRd)))
            else begin
                failures++;
                $display("FAIL reissue_busy rd=%0d busy=0x%0h", ifc.MdIssueRd, ifc.BusyMask);
            end
        end
        if (rst && ifc.RegWriteW && (ifc.RdW != 5'd0)) begin
            checks++;
            a_wb_busy: assert (!ifc.BusyMask[ifc.RdW])
            else begin
                failures++;
                $display("FAIL wb_to_busy rd=%0d busy=0x%0h", ifc.RdW, ifc.BusyMask);
            end
        end
    endtask

    // Inputs change 1 time unit after the posedge; outputs sampled at negedge.
    task automatic cyc();
        legality();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        rst = 1'b1;

        //            we    rd     res       iss   ird    mv    mrd     mres       e_we  e_wa   e_wd        rdy   stall busy
        tbl[0]  = mk(1'b1, 5'd5,  32'hAA,   1'b0, 5'd0, 1'b0, 5'd0,  32'h0,     1'b1, 5'd5,  32'hAA,    1'b1, 1'b0, 32'h0);
        tbl[1]  = mk(1'b1, 5'd0,  32'h55,   1'b0, 5'd0, 1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b1, 1'b0, 32'h0);
        tbl[2]  = mk(1'b0, 5'd0,  32'h0,    1'b1, 5'd7, 1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b1, 1'b0, 32'h0);
        tbl[3]  = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b1, 5'd7,  32'h1234,  1'b0, 5'd0,  32'h0,     1'b1, 1'b0, 32'h80);
        tbl[4]  = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd0,  32'h0,     1'b1, 5'd7,  32'h1234,  1'b1, 1'b0, 32'h80);
        tbl[5]  = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b1, 1'b0, 32'h0);
        tbl[6]  = mk(1'b1, 5'd1,  32'h101,  1'b0, 5'd0, 1'b1, 5'd9,  32'h900,   1'b1, 5'd1,  32'h101,   1'b1, 1'b0, 32'h0);
        tbl[7]  = mk(1'b1, 5'd1,  32'h102,  1'b0, 5'd0, 1'b1, 5'd10, 32'hA00,   1'b1, 5'd1,  32'h102,   1'b1, 1'b0, 32'h0);
        tbl[8]  = mk(1'b1, 5'd1,  32'h103,  1'b0, 5'd0, 1'b1, 5'd11, 32'hB00,   1'b1, 5'd1,  32'h103,   1'b0, 1'b0, 32'h0);
        tbl[9]  = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b1, 5'd11, 32'hB00,   1'b1, 5'd9,  32'h900,   1'b0, 1'b0, 32'h0);
        tbl[10] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b1, 5'd11, 32'hB00,   1'b1, 5'd10, 32'hA00,   1'b1, 1'b0, 32'h0);
        tbl[11] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd0,  32'h0,     1'b1, 5'd11, 32'hB00,   1'b1, 1'b0, 32'h0);
        tbl[12] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b1, 1'b0, 32'h0);

        // Power-on reset
        #2 rst = 1'b0;
        #1;
        chk("por_we",    32'(ifc.RfWE),     32'h0);
        chk("por_busy",  ifc.BusyMask,      32'h0);
        chk("por_ready", 32'(ifc.MdReady),  32'h1);
        chk("por_stall", 32'(ifc.StallReq), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Table: WB-only, drain, full queue
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].we, tbl[i].rd, tbl[i].res, tbl[i].iss, tbl[i].ird,
                  tbl[i].mv, tbl[i].mrd, tbl[i].mres);
            @(negedge clk);
            chk($sformatf("v%0d_we", i),    32'(ifc.RfWE),     32'(tbl[i].e_we));
            chk($sformatf("v%0d_wa", i),    32'(ifc.RfWA),     32'(tbl[i].e_wa));
            chk($sformatf("v%0d_wd", i),    ifc.RfWD,          tbl[i].e_wd);
            chk($sformatf("v%0d_rdy", i),   32'(ifc.MdReady),  32'(tbl[i].e_rdy));
            chk($sformatf("v%0d_stall", i), 32'(ifc.StallReq), 32'(tbl[i].e_stall));
            chk($sformatf("v%0d_busy", i),  ifc.BusyMask,      tbl[i].e_busy);
            cyc();
        end

        // Starvation: one queued entry behind continuous WB traffic
        drive(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b1, 5'd12, 32'hC0C);
        @(negedge clk);
        chk("st_push_rdy", 32'(ifc.MdReady), 32'h1);
        cyc();
        for (int j = 0; j < 6; j++) begin
            drive(1'b1, 5'd2, 32'h22 + 32'(j), 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
            @(negedge clk);
            chk($sformatf("st_wait%0d_stall", j), 32'(ifc.StallReq), (j >= 4) ? 32'h1 : 32'h0);
            chk($sformatf("st_wait%0d_wa", j),    32'(ifc.RfWA),     32'h2);
            cyc();
        end
        idle();
        @(negedge clk);
        chk("st_bubble_we",    32'(ifc.RfWE),     32'h1);
        chk("st_bubble_wa",    32'(ifc.RfWA),     32'd12);
        chk("st_bubble_wd",    ifc.RfWD,          32'hC0C);
        chk("st_bubble_stall", 32'(ifc.StallReq), 32'h1);
        cyc();
        @(negedge clk);
        chk("st_after_stall", 32'(ifc.StallReq), 32'h0);
        chk("st_after_we",    32'(ifc.RfWE),     32'h0);
        cyc();

        // Same-cycle pop of rd=3 and reissue of rd=3
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0);
        cyc();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h333);
        @(negedge clk);
        chk("sc_busy_set", ifc.BusyMask, 32'h8);
        cyc();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("sc_pop_wa", 32'(ifc.RfWA), 32'd3);
        chk("sc_pop_wd", ifc.RfWD,      32'h333);
        cyc();
        idle();
        @(negedge clk);
        chk("sc_busy_kept", ifc.BusyMask,     32'h8);
        chk("sc_idle_we",   32'(ifc.RfWE),    32'h0);
        cyc();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h334);
        cyc();
        idle();
        @(negedge clk);
        chk("sc_pop2_wd", ifc.RfWD, 32'h334);
        cyc();
        @(negedge clk);
        chk("sc_busy_clr", ifc.BusyMask, 32'h0);
        cyc();

        // Push and pop together at count=1 keep order and count
        drive(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 1'b1, 5'd13, 32'hD1);
        cyc();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd14, 32'hE1);
        @(negedge clk);
        chk("pp_first_wa", 32'(ifc.RfWA), 32'd13);
        chk("pp_first_wd", ifc.RfWD,      32'hD1);
        cyc();
        idle();
        @(negedge clk);
        chk("pp_second_wa", 32'(ifc.RfWA),    32'd14);
        chk("pp_second_wd", ifc.RfWD,         32'hE1);
        chk("pp_second_rdy", 32'(ifc.MdReady), 32'h1);
        cyc();
        @(negedge clk);
        chk("pp_empty_we", 32'(ifc.RfWE), 32'h0);
        cyc();

        // Reset in the middle of traffic with a full queue
        drive(1'b1, 5'd1, 32'h7, 1'b1, 5'd20, 1'b0, 5'd0, 32'h0);
        cyc();
        drive(1'b1, 5'd1, 32'h8, 1'b0, 5'd0, 1'b1, 5'd20, 32'h2020);
        cyc();
        drive(1'b1, 5'd1, 32'h9, 1'b0, 5'd0, 1'b1, 5'd21, 32'h2121);
        cyc();
        drive(1'b1, 5'd1, 32'hA, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("mr_pre_rdy",  32'(ifc.MdReady), 32'h0);
        chk("mr_pre_busy", ifc.BusyMask,     32'h0010_0000);
        rst = 1'b0;
        #1;
        chk("mr_we",    32'(ifc.RfWE),     32'h0);
        chk("mr_busy",  ifc.BusyMask,      32'h0);
        chk("mr_rdy",   32'(ifc.MdReady),  32'h1);
        chk("mr_stall", 32'(ifc.StallReq), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();
        @(negedge clk);
        chk("mr_after_we",  32'(ifc.RfWE),    32'h0);
        chk("mr_after_rdy", 32'(ifc.MdReady), 32'h1);
        cyc();
        @(negedge clk);
        chk("mr_after2_we", 32'(ifc.RfWE), 32'h0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
